// File: rtl/multi_ctrl_fsm_pkg.sv
// Encodings shared by the multicycle RV32I control FSM and the branch/jump
// transfer logic: state codes, opcodes, funct fields and datapath selects.
package multi_ctrl_fsm_pkg;

   localparam int unsigned STATE_CODE_W = 6;

   typedef enum logic [STATE_CODE_W-1:0] {
      STATE_FETCH  = 6'd0,
      STATE_DECODE = 6'd1,
      STATE_LWSW   = 6'd2,
      STATE_LW     = 6'd3,
      STATE_LW_WB  = 6'd4,
      STATE_SW     = 6'd5,
      STATE_RTYPE  = 6'd6,
      STATE_IMM    = 6'd7,
      STATE_ALU_WB = 6'd8,
      STATE_BRANCH = 6'd9,
      STATE_JAL    = 6'd10,
      STATE_JALR   = 6'd11,
      STATE_LUI    = 6'd12,
      STATE_AUIPC  = 6'd13,
      STATE_MULDIV = 6'd14,
      STATE_ERROR  = 6'd63
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_PASSB  = 2'b11;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic [1:0] ORIGPC_PC4    = 2'b00;
   localparam logic [1:0] ORIGPC_BRANCH = 2'b01;
   localparam logic [1:0] ORIGPC_JAL    = 2'b10;
   localparam logic [1:0] ORIGPC_JALR   = 2'b11;

   localparam logic [1:0] ALUA_PCBACK = 2'b00;
   localparam logic [1:0] ALUA_RS1    = 2'b01;
   localparam logic [1:0] ALUA_PC     = 2'b10;
   localparam logic [1:0] ALUA_ZERO   = 2'b11;

   localparam logic [1:0] ALUB_RS2  = 2'b00;
   localparam logic [1:0] ALUB_FOUR = 2'b01;
   localparam logic [1:0] ALUB_IMM  = 2'b10;

endpackage

// File: rtl/multi_ctrl_fsm_mem_wait_timer.sv
// Shared-memory wait timer: counts consecutive not-ready cycles of a memory
// phase and flags the cycle that would reach TIMEOUT (0 disables the timer).
// Ports: clk, rst_n; active = FSM is in a memory phase; ready = memory handshake;
//        expired_c = combinational timeout strobe for the next-state logic.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ready,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   logic [CNT_W-1:0] cnt;
   logic             waiting_c;

   assign waiting_c = active && !ready;

   // Count stalled cycles; any ready or non-memory cycle restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (waiting_c && (TIMEOUT != 0)) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= '0;
      end
   end

   // Fires on the TIMEOUT-th consecutive stalled cycle.
   assign expired_c = (TIMEOUT != 0) && waiting_c && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/multi_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and select.
// Optional feature: define RV32M_EN to route OP/funct7=0000001 through MULDIV.
// Ports: iCLK/iRST_n clock and async active-low reset; iOpcode/iFunct3/iFunct7
//        IR fields; iMemReady shared-memory handshake; iMulDivDone M-unit done;
//        oState/oCOrigPC to the transfer logic; oEscrevePC/oEscrevePCB/oEscreveIR
//        fetch writes; oIouD/oLeMem/oEscreveMem memory; oOrigAULA/oOrigBULA/oALUOp
//        ALU control; oMem2Reg/oEscreveReg register file; oError sticky error.
module multi_ctrl_fsm
   import multi_ctrl_fsm_pkg::*;
#(
   parameter int unsigned STATE_W  = 6,
   parameter int unsigned FETCH_TO = 15
) (
   input  logic               iCLK,
   input  logic               iRST_n,
   input  logic [6:0]         iOpcode,
   input  logic [2:0]         iFunct3,
   input  logic [6:0]         iFunct7,
   input  logic               iMemReady,
   input  logic               iMulDivDone,
   output logic [STATE_W-1:0] oState,
   output logic [1:0]         oCOrigPC,
   output logic               oEscrevePC,
   output logic               oEscrevePCB,
   output logic               oEscreveIR,
   output logic               oIouD,
   output logic               oLeMem,
   output logic               oEscreveMem,
   output logic [1:0]         oOrigAULA,
   output logic [1:0]         oOrigBULA,
   output logic [1:0]         oALUOp,
   output logic [1:0]         oMem2Reg,
   output logic               oEscreveReg,
   output logic               oError
);

   state_t state, state_nxt;
   logic   is_store;
   logic   error_q;
   logic   mem_phase_c, timeout_c, fetch_done_c;
   logic   le_mem_c, escreve_mem_c, escreve_reg_c, iou_d_c;
   logic [1:0] orig_a_c, orig_b_c, alu_op_c, mem2reg_c, corig_pc_c;
   logic   unused_c;

`ifdef RV32M_EN
   assign unused_c = ^iFunct3;
`else
   assign unused_c = ^{iFunct3, iMulDivDone};
`endif

   assign mem_phase_c = (state == STATE_FETCH) || (state == STATE_LW) || (state == STATE_SW);

   mem_wait_timer #(.TIMEOUT(FETCH_TO)) u_mem_wait_timer (
      .clk       (iCLK),
      .rst_n     (iRST_n),
      .active    (mem_phase_c),
      .ready     (iMemReady),
      .expired_c (timeout_c)
   );

   // State register; load/store direction is captured while the opcode is decoded.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state    <= STATE_FETCH;
         is_store <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         error_q <= (state_nxt == STATE_ERROR);
         if (state == STATE_DECODE) begin
            is_store <= (iOpcode == OPC_STORE);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         STATE_FETCH: begin
            if (timeout_c)      state_nxt = STATE_ERROR;
            else if (iMemReady) state_nxt = STATE_DECODE;
         end
         STATE_DECODE: begin
            case (iOpcode)
               OPC_LOAD, OPC_STORE: state_nxt = STATE_LWSW;
               OPC_OP: begin
                  if (iFunct7 == F7_MULDIV) begin
`ifdef RV32M_EN
                     state_nxt = STATE_MULDIV;
`else
                     state_nxt = STATE_ERROR;
`endif
                  end else begin
                     state_nxt = STATE_RTYPE;
                  end
               end
               OPC_OP_IMM: state_nxt = STATE_IMM;
               OPC_BRANCH: state_nxt = STATE_BRANCH;
               OPC_JAL:    state_nxt = STATE_JAL;
               OPC_JALR:   state_nxt = STATE_JALR;
               OPC_LUI:    state_nxt = STATE_LUI;
               OPC_AUIPC:  state_nxt = STATE_AUIPC;
               default:    state_nxt = STATE_ERROR;
            endcase
         end
         STATE_LWSW: state_nxt = is_store ? STATE_SW : STATE_LW;
         STATE_LW: begin
            if (timeout_c)      state_nxt = STATE_ERROR;
            else if (iMemReady) state_nxt = STATE_LW_WB;
         end
         STATE_SW: begin
            if (timeout_c)      state_nxt = STATE_ERROR;
            else if (iMemReady) state_nxt = STATE_FETCH;
         end
         STATE_RTYPE, STATE_IMM: state_nxt = STATE_ALU_WB;
         STATE_LW_WB, STATE_ALU_WB, STATE_BRANCH, STATE_JAL,
         STATE_JALR, STATE_LUI, STATE_AUIPC: state_nxt = STATE_FETCH;
`ifdef RV32M_EN
         STATE_MULDIV: if (iMulDivDone) state_nxt = STATE_ALU_WB;
`endif
         STATE_ERROR: state_nxt = STATE_ERROR;
         default:     state_nxt = STATE_ERROR;
      endcase
   end

   // Output decode from the registered state; selects default to FETCH values.
   always_comb begin
      le_mem_c      = 1'b0;
      escreve_mem_c = 1'b0;
      escreve_reg_c = 1'b0;
      iou_d_c       = 1'b0;
      orig_a_c      = ALUA_PC;
      orig_b_c      = ALUB_FOUR;
      alu_op_c      = ALUOP_ADD;
      mem2reg_c     = M2R_ALUOUT;
      corig_pc_c    = ORIGPC_PC4;
      case (state)
         STATE_FETCH:  le_mem_c = 1'b1;
         STATE_DECODE: begin orig_a_c = ALUA_PCBACK; orig_b_c = ALUB_IMM; end
         STATE_LWSW:   begin orig_a_c = ALUA_RS1;    orig_b_c = ALUB_IMM; end
         STATE_LW:     begin le_mem_c = 1'b1; iou_d_c = 1'b1; end
         STATE_LW_WB:  begin escreve_reg_c = 1'b1; mem2reg_c = M2R_MDR; end
         STATE_SW:     begin escreve_mem_c = 1'b1; iou_d_c = 1'b1; end
         STATE_RTYPE:  begin orig_a_c = ALUA_RS1; orig_b_c = ALUB_RS2; alu_op_c = ALUOP_FUNCT; end
         STATE_IMM:    begin orig_a_c = ALUA_RS1; orig_b_c = ALUB_IMM; alu_op_c = ALUOP_FUNCT; end
         STATE_ALU_WB: escreve_reg_c = 1'b1;
         STATE_BRANCH: begin
            orig_a_c = ALUA_RS1; orig_b_c = ALUB_RS2; alu_op_c = ALUOP_BRANCH;
            corig_pc_c = ORIGPC_BRANCH;
         end
         STATE_JAL:    begin corig_pc_c = ORIGPC_JAL; escreve_reg_c = 1'b1; mem2reg_c = M2R_PC; end
         STATE_JALR: begin
            orig_a_c = ALUA_RS1; orig_b_c = ALUB_IMM; corig_pc_c = ORIGPC_JALR;
            escreve_reg_c = 1'b1; mem2reg_c = M2R_PC;
         end
         STATE_LUI: begin
            orig_a_c = ALUA_ZERO; orig_b_c = ALUB_IMM; alu_op_c = ALUOP_PASSB;
            escreve_reg_c = 1'b1;
         end
         STATE_AUIPC: begin
            orig_a_c = ALUA_PCBACK; orig_b_c = ALUB_IMM; escreve_reg_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Fetch writes complete in the same cycle memory returns the instruction.
   assign fetch_done_c = iRST_n && (state == STATE_FETCH) && iMemReady;

   assign oState      = STATE_W'(state);
   assign oCOrigPC    = corig_pc_c;
   assign oEscrevePC  = fetch_done_c;
   assign oEscrevePCB = fetch_done_c;
   assign oEscreveIR  = fetch_done_c;
   assign oIouD       = iou_d_c;
   assign oLeMem      = iRST_n && le_mem_c;
   assign oEscreveMem = iRST_n && escreve_mem_c;
   assign oOrigAULA   = orig_a_c;
   assign oOrigBULA   = orig_b_c;
   assign oALUOp      = alu_op_c;
   assign oMem2Reg    = mem2reg_c;
   assign oEscreveReg = iRST_n && escreve_reg_c;
   assign oError      = error_q;

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Self-checking bench for multi_ctrl_fsm: directed instruction sequences plus
// randomized opcodes and memory stalls against a per-instruction phase model.
module tb_multi_ctrl_fsm;
   import multi_ctrl_fsm_pkg::*;

   localparam int unsigned TO = 15;

   logic       iCLK = 1'b0;
   logic       iRST_n = 1'b1;
   logic [6:0] iOpcode = '0;
   logic [2:0] iFunct3 = '0;
   logic [6:0] iFunct7 = '0;
   logic       iMemReady = 1'b0;
   logic       iMulDivDone = 1'b0;
   logic [5:0] oState;
   logic [1:0] oCOrigPC, oOrigAULA, oOrigBULA, oALUOp, oMem2Reg;
   logic       oEscrevePC, oEscrevePCB, oEscreveIR, oIouD, oLeMem, oEscreveMem, oEscreveReg, oError;

   multi_ctrl_fsm #(.STATE_W(6), .FETCH_TO(TO)) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iOpcode(iOpcode), .iFunct3(iFunct3), .iFunct7(iFunct7),
      .iMemReady(iMemReady), .iMulDivDone(iMulDivDone), .oState(oState), .oCOrigPC(oCOrigPC),
      .oEscrevePC(oEscrevePC), .oEscrevePCB(oEscrevePCB), .oEscreveIR(oEscreveIR), .oIouD(oIouD),
      .oLeMem(oLeMem), .oEscreveMem(oEscreveMem), .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA),
      .oALUOp(oALUOp), .oMem2Reg(oMem2Reg), .oEscreveReg(oEscreveReg), .oError(oError)
   );

   always #5 iCLK = ~iCLK;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Reference model: remaining phases of the current instruction.
   state_t      cur;
   state_t      plan_q[$];
   int unsigned stall_cnt, ins_cyc, ins_wait, ins_base;
   logic        force_low = 1'b0;
   logic        rdy_q[$];
   logic [6:0]  opc_q[$];
   logic [6:0]  f7_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] pick_opc(input int unsigned k);
      case (k)
         0: return 7'h03;
         1: return 7'h23;
         2: return 7'h33;
         3: return 7'h13;
         4: return 7'h63;
         5: return 7'h6F;
         6: return 7'h67;
         7: return 7'h37;
         8: return 7'h17;
         9: return 7'h7F;
         default: return 7'($urandom);
      endcase
   endfunction

   // Start a new instruction: drive IR fields and lay out its phases.
   task automatic new_instr();
      logic [6:0] opc, f7;
      if (opc_q.size() != 0) begin
         opc = opc_q.pop_front();
         f7  = f7_q.pop_front();
      end else begin
         opc = pick_opc($urandom_range(0, 11));
         case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'h01;
         endcase
      end
      iOpcode = opc;
      iFunct7 = f7;
      iFunct3 = 3'($urandom);
      plan_q.delete();
      plan_q.push_back(STATE_DECODE);
      ins_base = 3;
      case (opc)
         7'h03: begin plan_q.push_back(STATE_LWSW); plan_q.push_back(STATE_LW);
                      plan_q.push_back(STATE_LW_WB); ins_base = 5; end
         7'h23: begin plan_q.push_back(STATE_LWSW); plan_q.push_back(STATE_SW); ins_base = 4; end
         7'h33: begin
            if (f7 == 7'h01) begin
`ifdef RV32M_EN
               plan_q.push_back(STATE_MULDIV); plan_q.push_back(STATE_ALU_WB); ins_base = 4;
`else
               plan_q.push_back(STATE_ERROR);
`endif
            end else begin
               plan_q.push_back(STATE_RTYPE); plan_q.push_back(STATE_ALU_WB); ins_base = 4;
            end
         end
         7'h13: begin plan_q.push_back(STATE_IMM); plan_q.push_back(STATE_ALU_WB); ins_base = 4; end
         7'h63: plan_q.push_back(STATE_BRANCH);
         7'h6F: plan_q.push_back(STATE_JAL);
         7'h67: plan_q.push_back(STATE_JALR);
         7'h37: plan_q.push_back(STATE_LUI);
         7'h17: plan_q.push_back(STATE_AUIPC);
         default: plan_q.push_back(STATE_ERROR);
      endcase
      ins_cyc  = 0;
      ins_wait = 0;
   endtask

   task automatic do_reset();
      #2;
      iRST_n    = 1'b0;
      iMemReady = 1'b1;
      #1;
      check_eq("rst_state",   32'(oState),      32'(STATE_FETCH));
      check_eq("rst_error",   32'(oError),      32'd0);
      check_eq("rst_pc",      32'(oEscrevePC),  32'd0);
      check_eq("rst_pcb",     32'(oEscrevePCB), 32'd0);
      check_eq("rst_ir",      32'(oEscreveIR),  32'd0);
      check_eq("rst_lemem",   32'(oLeMem),      32'd0);
      check_eq("rst_wrmem",   32'(oEscreveMem), 32'd0);
      check_eq("rst_wrreg",   32'(oEscreveReg), 32'd0);
      check_eq("rst_orig_a",  32'(oOrigAULA),   32'(2'b10));
      check_eq("rst_orig_b",  32'(oOrigBULA),   32'(2'b01));
      @(posedge iCLK);
      #1;
      iRST_n    = 1'b1;
      cur       = STATE_FETCH;
      stall_cnt = 0;
      new_instr();
   endtask

   // One clock cycle: drive, compare at the falling edge, then advance the model.
   task automatic step();
      logic       stalled, mem_phase;
      logic [1:0] exp_m2r;
      if (rdy_q.size() != 0) iMemReady = rdy_q.pop_front();
      else if (force_low)    iMemReady = 1'b0;
      else                   iMemReady = ($urandom_range(0, 3) != 0);
      iMulDivDone = ($urandom_range(0, 2) == 0);
      mem_phase = (cur == STATE_FETCH) || (cur == STATE_LW) || (cur == STATE_SW);

      @(negedge iCLK);
      check_eq("state",     32'(oState),      32'(cur));
      check_eq("le_mem",    32'(oLeMem),      32'((cur == STATE_FETCH) || (cur == STATE_LW)));
      check_eq("iou_d",     32'(oIouD),       32'((cur == STATE_LW) || (cur == STATE_SW)));
      check_eq("wr_mem",    32'(oEscreveMem), 32'(cur == STATE_SW));
      check_eq("wr_pc",     32'(oEscrevePC),  32'((cur == STATE_FETCH) && iMemReady));
      check_eq("wr_ir",     32'(oEscreveIR),  32'((cur == STATE_FETCH) && iMemReady));
      check_eq("wr_pcb",    32'(oEscrevePCB), 32'((cur == STATE_FETCH) && iMemReady));
      check_eq("error",     32'(oError),      32'(cur == STATE_ERROR));
      check_eq("wr_reg",    32'(oEscreveReg), 32'(cur inside {STATE_LW_WB, STATE_ALU_WB, STATE_JAL,
                                                             STATE_JALR, STATE_LUI, STATE_AUIPC}));
      if (cur inside {STATE_LW_WB, STATE_ALU_WB, STATE_JAL, STATE_JALR}) begin
         exp_m2r = (cur == STATE_LW_WB) ? 2'b01 : (cur == STATE_ALU_WB) ? 2'b00 : 2'b10;
         check_eq("mem2reg", 32'(oMem2Reg), 32'(exp_m2r));
      end
      if (cur inside {STATE_FETCH, STATE_BRANCH, STATE_JAL, STATE_JALR})
         check_eq("corig_pc", 32'(oCOrigPC), (cur == STATE_BRANCH) ? 32'd1 : (cur == STATE_JAL) ? 32'd2 :
                                             (cur == STATE_JALR) ? 32'd3 : 32'd0);
      if (cur inside {STATE_RTYPE, STATE_IMM, STATE_BRANCH})
         check_eq("alu_op", 32'(oALUOp), (cur == STATE_BRANCH) ? 32'd1 : 32'd2);

      @(posedge iCLK);
      #1;
      stalled = (mem_phase && !iMemReady) || ((cur == STATE_MULDIV) && !iMulDivDone);
      ins_cyc++;
      if (cur == STATE_ERROR) begin
         // sticky until reset
      end else if (stalled) begin
         ins_wait++;
         if (mem_phase) begin
            stall_cnt++;
            if (stall_cnt == TO) cur = STATE_ERROR;
         end
      end else begin
         if (mem_phase) stall_cnt = 0;
         if (plan_q.size() != 0) begin
            cur = plan_q.pop_front();
         end else begin
            check_eq("ins_len", ins_cyc, ins_base + ins_wait);
            cur = STATE_FETCH;
            new_instr();
         end
      end
   endtask

   initial begin
      int unsigned n, err_run;

      // add, lw (3 stall cycles in LW), beq -- all other ready slots high
      opc_q = '{7'h33, 7'h03, 7'h63};
      f7_q  = '{7'h00, 7'h00, 7'h00};
      rdy_q = '{1'b1, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b1, 1'b1, 1'b1};
      do_reset();
      repeat (4 + 8 + 3) step();
      check_eq("dir_back_fetch", 32'(oState), 32'(STATE_FETCH));

      // Illegal opcode: sticky error, cleared only by reset
      opc_q = '{7'h7F};
      f7_q  = '{7'h00};
      do_reset();
      n = 0;
      while (cur != STATE_ERROR && n < 40) begin step(); n++; end
      check_eq("illegal_err", 32'(oState), 32'(STATE_ERROR));
      repeat (100) step();
      do_reset();

      // Fetch timeout after exactly TO stalled cycles
      force_low = 1'b1;
      n = 0;
      while (oState != 6'(STATE_ERROR) && n < 40) begin step(); n++; end
      force_low = 1'b0;
      check_eq("timeout_cycles", n, TO);
      check_eq("timeout_err", 32'(oError), 32'd1);

      // mul
      opc_q = '{7'h33};
      f7_q  = '{7'h01};
      rdy_q = '{1'b1};
      do_reset();
      repeat (2) step();
`ifndef RV32M_EN
      check_eq("mul_no_m", 32'(oState), 32'(STATE_ERROR));
`endif
      repeat (6) step();

      // Randomized instruction stream
      do_reset();
      err_run = 0;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (cur == STATE_ERROR) begin
            err_run++;
            if (err_run > 4) begin
               do_reset();
               err_run = 0;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
